// File: rtl/inert_spi_mstr.sv
// 16-bit SPI master (mode 3, SCLK = clk/16) for inertial sensor register access.
// Define INERT_SPI_MISO_SYNC_EN to pass MISO through a two-flop synchronizer before sampling.
module inert_spi_mstr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  // Handshake: wrt is a one-cycle strobe accepted only in IDLE with cmd valid the
  // same cycle; done rises with SS_n and stays high until the next accepted wrt.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [15:0] shft_reg_q, shft_reg_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        skip_q, skip_d;
  logic        miso_smpl_q, miso_smpl_d;
  logic        ss_n_q, ss_n_d;
  logic        done_q, done_d;
  logic        miso_in;

`ifdef INERT_SPI_MISO_SYNC_EN
  logic miso_ff1_q, miso_ff1_d;
  logic miso_ff2_q, miso_ff2_d;

  always_comb begin
    miso_ff1_d = MISO;
    miso_ff2_d = miso_ff1_q;
  end

  // Sync flops idle high so a floating/pulled-up MISO looks quiet out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_ff1_q <= 1'b1;
      miso_ff2_q <= 1'b1;
    end else begin
      miso_ff1_q <= miso_ff1_d;
      miso_ff2_q <= miso_ff2_d;
    end
  end

  assign miso_in = miso_ff2_q;
`else
  assign miso_in = MISO;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    shft_reg_d  = shft_reg_q;
    bit_cnt_d   = bit_cnt_q;
    skip_d      = skip_q;
    miso_smpl_d = miso_smpl_q;
    ss_n_d      = ss_n_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        if (wrt) begin
          shft_reg_d = cmd;
          div_d      = 4'b1011;
          done_d     = 1'b0;
          ss_n_d     = 1'b0;
          bit_cnt_d  = 5'd0;
          skip_d     = 1'b1;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        div_d = div_q + 4'd1;
        if (div_q == 4'b0111) begin
          miso_smpl_d = miso_in;
        end
        // The first SCLK fall only exists to enter mode 3 cleanly; it shifts nothing.
        if (div_q == 4'b1111) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            shft_reg_d = {shft_reg_q[14:0], miso_smpl_q};
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_d == 5'd16) begin
              ss_n_d  = 1'b1;
              done_d  = 1'b1;
              div_d   = 4'b1111;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= 4'b1111;
      shft_reg_q  <= 16'h0000;
      bit_cnt_q   <= 5'd0;
      skip_q      <= 1'b0;
      miso_smpl_q <= 1'b0;
      ss_n_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      shft_reg_q  <= shft_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      skip_q      <= skip_d;
      miso_smpl_q <= miso_smpl_d;
      ss_n_q      <= ss_n_d;
      done_q      <= done_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = div_q[3];
  assign MOSI    = ~ss_n_q & shft_reg_q[15];
  assign done    = done_q;
  assign rd_data = shft_reg_q;

endmodule

// File: tb/tb_inert_spi_mstr.sv
// Directed bench for inert_spi_mstr: loopback and a small mode-3 sensor register model.
module tb_inert_spi_mstr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        done;
  logic [15:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic loop_en = 1'b1;
  logic model_miso = 1'b0;

  assign MISO = loop_en ? MOSI : model_miso;

  inert_spi_mstr dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrt    (wrt),
    .cmd    (cmd),
    .MISO   (MISO),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .done   (done),
    .rd_data(rd_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- sensor register model (mode 3 slave) ----------------
  logic [7:0]  regs [0:127];
  logic [15:0] rx = 16'h0000;
  logic [7:0]  cmd_byte = 8'h00;
  int          rise_cnt = 0;
  logic        ss_prev = 1'b1;
  logic        sclk_prev = 1'b1;

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[7'h0F] = 8'h6A;
  end

  always @(SS_n, SCLK) begin
    if (ss_prev === 1'b1 && SS_n === 1'b0) begin
      rise_cnt   = 0;
      rx         = 16'h0000;
      model_miso = 1'b0;
    end else if (ss_prev === 1'b0 && SS_n === 1'b1) begin
      if (rise_cnt == 16 && rx[15] == 1'b0) regs[rx[14:8]] = rx[7:0];
    end
    if (SS_n === 1'b0) begin
      if (sclk_prev === 1'b0 && SCLK === 1'b1) begin
        rx = {rx[14:0], MOSI};
        rise_cnt++;
        if (rise_cnt == 8) cmd_byte = rx[7:0];
      end else if (sclk_prev === 1'b1 && SCLK === 1'b0) begin
        if (rise_cnt >= 8 && rise_cnt < 16 && cmd_byte[7])
          model_miso = regs[cmd_byte[6:0]][15 - rise_cnt];
        else
          model_miso = 1'b0;
      end
    end
    ss_prev   = SS_n;
    sclk_prev = SCLK;
  end

  // ---------------- MOSI setup/hold monitor (8 clks = 80 time units) ----------------
  longint t_rise = -1000;
  longint t_mosi = -1000;
  int     mosi_viol = 0;
  logic   mon_en = 1'b1;
  logic   mosi_prev = 1'b0;
  logic   sclk_mon_prev = 1'b1;

  always @(MOSI, SCLK) begin
    if (MOSI !== mosi_prev) begin
      if (mon_en && ($time - t_rise) < 80) mosi_viol++;
      t_mosi = $time;
    end
    if (sclk_mon_prev === 1'b0 && SCLK === 1'b1) begin
      if (mon_en && ($time - t_mosi) < 80) mosi_viol++;
      t_rise = $time;
    end
    mosi_prev     = MOSI;
    sclk_mon_prev = SCLK;
  end

  // ---------------- driver ----------------
  // Called just after a sampling point; pulses wrt so edge E0 is the next posedge,
  // then samples #1 after each edge E0+k until done or the cycle budget runs out.
  task automatic xfer(input logic [15:0] c, input bit inj_wrt,
                      output int done_at, output int rises, output int ssn_low,
                      output int first_fall);
    logic prev_sclk;
    done_at    = -1;
    rises      = 0;
    ssn_low    = 0;
    first_fall = -1;
    cmd = c;
    wrt = 1'b1;
    @(posedge clk); #1;
    wrt = 1'b0;
    cmd = 16'hDEAD;
    prev_sclk = SCLK;
    if (!SS_n) ssn_low++;
    for (int k = 1; k <= 320 && done_at < 0; k++) begin
      if (inj_wrt && k == 100) begin
        cmd = 16'hFFFF;
        wrt = 1'b1;
      end
      @(posedge clk); #1;
      if (inj_wrt && k == 100) begin
        wrt = 1'b0;
        cmd = 16'hDEAD;
      end
      if (SCLK && !prev_sclk) rises++;
      if (!SCLK && first_fall < 0) first_fall = k;
      prev_sclk = SCLK;
      if (!SS_n) ssn_low++;
      if (done) done_at = k;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if (rd_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({SS_n, SCLK, MOSI, done} !== 4'b1100) begin
        n_bad++;
        $display("FAIL reset_idle cyc %0d: got SS_n/SCLK/MOSI/done=%b expected 1100",
                 i, {SS_n, SCLK, MOSI, done});
      end
    end
  endtask

  task automatic test_loopback();
    int d, r, s, f;
    loop_en   = 1'b1;
    mosi_viol = 0;
    xfer(16'hA5C3, 1'b0, d, r, s, f);
    n_cmp++;
    if (d !== 261) begin n_bad++; $display("FAIL loop_done_time: got %0d expected 261", d); end
    n_cmp++;
    if (r !== 16) begin n_bad++; $display("FAIL loop_sclk_rises: got %0d expected 16", r); end
    n_cmp++;
    if (s !== 261) begin n_bad++; $display("FAIL loop_ssn_low: got %0d expected 261", s); end
    n_cmp++;
    if (f !== 5) begin n_bad++; $display("FAIL loop_first_fall: got %0d expected 5", f); end
    n_cmp++;
    if (rd_data !== 16'hA5C3) begin
      n_bad++; $display("FAIL loop_rd_data: got %h expected a5c3", rd_data);
    end
    n_cmp++;
    if (mosi_viol !== 0) begin
      n_bad++; $display("FAIL loop_mosi_stable: got %0d violations expected 0", mosi_viol);
    end
    idle(10);
    n_cmp++;
    if ({done, SS_n, SCLK, MOSI} !== 4'b1110) begin
      n_bad++;
      $display("FAIL loop_done_held: got done/SS_n/SCLK/MOSI=%b expected 1110",
               {done, SS_n, SCLK, MOSI});
    end
  endtask

  task automatic test_who_am_i();
    int d, r, s, f;
    loop_en = 1'b0;
    xfer(16'h8F00, 1'b0, d, r, s, f);
    n_cmp++;
    if (rd_data[7:0] !== 8'h6A) begin
      n_bad++; $display("FAIL who_am_i: got %h expected 6a", rd_data[7:0]);
    end
    n_cmp++;
    if (d !== 261) begin n_bad++; $display("FAIL who_am_i_done: got %0d expected 261", d); end
    idle(5);
  endtask

  task automatic test_reg_write();
    int d, r, s, f;
    loop_en = 1'b0;
    xfer(16'h0D02, 1'b0, d, r, s, f);
    n_cmp++;
    if (regs[7'h0D] !== 8'h02) begin
      n_bad++; $display("FAIL reg_write_model: got %h expected 02", regs[7'h0D]);
    end
    idle(3);
    xfer(16'h8D00, 1'b0, d, r, s, f);
    n_cmp++;
    if (rd_data[7:0] !== 8'h02) begin
      n_bad++; $display("FAIL reg_readback: got %h expected 02", rd_data[7:0]);
    end
    idle(5);
  endtask

  task automatic test_ignored_wrt();
    int d, r, s, f;
    loop_en = 1'b1;
    xfer(16'h1234, 1'b1, d, r, s, f);
    n_cmp++;
    if (rd_data !== 16'h1234) begin
      n_bad++; $display("FAIL ignored_wrt_data: got %h expected 1234", rd_data);
    end
    n_cmp++;
    if (d !== 261) begin n_bad++; $display("FAIL ignored_wrt_done: got %0d expected 261", d); end
    n_cmp++;
    if (r !== 16) begin n_bad++; $display("FAIL ignored_wrt_rises: got %0d expected 16", r); end
    idle(5);
  endtask

  task automatic test_back_to_back();
    int d, r, s, f;
    loop_en = 1'b1;
    xfer(16'h3C5A, 1'b0, d, r, s, f);
    n_cmp++;
    if (rd_data !== 16'h3C5A) begin
      n_bad++; $display("FAIL b2b_first_data: got %h expected 3c5a", rd_data);
    end
    n_cmp++;
    if (SS_n !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_ssn: got %b expected 1", SS_n); end
    xfer(16'hC3A5, 1'b0, d, r, s, f);
    n_cmp++;
    if (s !== 261) begin n_bad++; $display("FAIL b2b_ssn_low: got %0d expected 261", s); end
    n_cmp++;
    if (d !== 261) begin n_bad++; $display("FAIL b2b_done_time: got %0d expected 261", d); end
    n_cmp++;
    if (rd_data !== 16'hC3A5) begin
      n_bad++; $display("FAIL b2b_second_data: got %h expected c3a5", rd_data);
    end
    idle(5);
  endtask

  task automatic test_reset_mid();
    int early_done = 0;
    int late_done  = 0;
    loop_en = 1'b1;
    mon_en  = 1'b0;
    cmd = 16'h5555;
    wrt = 1'b1;
    @(posedge clk); #1;
    wrt = 1'b0;
    for (int k = 1; k < 130; k++) begin
      @(posedge clk); #1;
      if (done) early_done++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({SS_n, SCLK, MOSI, done} !== 4'b1100) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got SS_n/SCLK/MOSI/done=%b expected 1100",
               {SS_n, SCLK, MOSI, done});
    end
    n_cmp++;
    if (rd_data !== 16'h0000) begin
      n_bad++; $display("FAIL rst_mid_rd_data: got %h expected 0000", rd_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (done || !SS_n) late_done++;
    end
    n_cmp++;
    if (early_done + late_done !== 0) begin
      n_bad++;
      $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", early_done + late_done);
    end
    mon_en = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_loopback();
    test_who_am_i();
    test_reg_write();
    test_ignored_wrt();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inert_spi_mstr.md
# inert_spi_mstr

16-bit SPI master that performs every register access to the inertial sensor (LSM6DSL-class device in `SegwayModel`). It sits directly upstream of `inert_intf`'s SPI pins. `inert_intf`'s init/read sequencer issues a command word with a single-cycle `wrt`, waits for `done`, and takes the returned sensor byte from `rd_data`. The block generates `SS_n`, `SCLK` and `MOSI`, and samples `MISO` in SPI mode 3:
- SCLK idles high.
- MOSI changes on SCLK fall.
- MISO is sampled on SCLK rise.

## Interface
Parameters: none; SCLK is fixed at clk/16.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `wrt`  in  1  one-cycle start strobe; `cmd` is valid the same cycle
- `cmd`  in  16  word to transmit, MSB first
- `MISO`  in  1  serial data from the sensor
- `SS_n`  out  1  slave select, active-low
- `SCLK`  out  1  serial clock
- `MOSI`  out  1  serial data to the sensor
- `done`  out  1  transaction complete; held high until the next `wrt` or reset
- `rd_data`  out  16  word shifted in from MISO (sensor data in [7:0])

## Operation
State machine states:
- **IDLE**
  - `SS_n`=1, `SCLK`=1, `done` holds its value.
  - `wrt`=1 does all of the following, then goes to SHIFT:
    - loads `shft_reg`<=`cmd`
    - sets `div`<=4'b1011
    - clears `done` and sets `SS_n`<=0
    - clears the bit counter and sets the `skip` flag
- **SHIFT**
  - `div` increments every clk, and `SCLK`=`div[3]`.
  - Sample: when `div`==4'b0111 (the cycle before SCLK rises), `miso_smpl`<=MISO.
  - Shift: when `div`==4'b1111 (the cycle before SCLK falls):
    - If `skip`, clear `skip` only; no shift.
    - Otherwise `shft_reg`<={`shft_reg`[14:0], `miso_smpl`} and the bit counter increments.
  - When the bit counter reaches 16:
    - that same edge sets `SS_n`<=1, `done`<=1, and freezes `div` at 4'b1111, so SCLK stays high and never falls;
    - next state is IDLE.
- `MOSI` = `shft_reg[15]`; it is driven whenever `SS_n`=0.
- `rd_data` = `shft_reg` (continuous).
- `wrt` while in SHIFT: ignored, with no effect on the transaction in flight.
- `wrt` in the same cycle `done` rises: ignored, because the FSM is still in SHIFT on that cycle.
- Bit counter: 5 bits, compared against 16, and never wraps within a transaction.

## Timing
- Reset values: `SS_n`=1, `SCLK`=1, `MOSI`=0, `done`=0, `rd_data`=16'h0000, `div`=4'b1111, state IDLE.
- With `wrt` high at edge E0, `SS_n` falls after E0.
- First SCLK fall occurs after E0+5; this is the skipped shift.
- Exactly 16 SCLK rising edges follow, one every 16 clks.
- `SS_n` rises and `done` rises on edge E0+261. SS_n-low duration is therefore exactly 261 clks.
- Back-to-back: `wrt` in the first cycle after `done` is accepted; the next `SS_n` fall comes 1 clk after `SS_n` rose.
- Reset asserted mid-transaction:
  - On the next clk edge, all outputs return to their reset values and the state returns to IDLE.
  - The partial `shft_reg` is cleared.
  - No `done` pulse is produced.
- `MOSI` is stable for at least 8 clks on both sides of every SCLK rise.

## Configuration
- `INERT_SPI_MISO_SYNC_EN` defined:
  - MISO passes through two flops clocked by `clk` before the sample point.
  - `miso_smpl` therefore captures the MISO level from 2 clks before `div`==4'b0111.
  - This is still 6 clks after the previous SCLK fall, so the shifted data is unchanged.
  - Both sync flops reset to 1.
- Undefined: raw MISO is sampled directly. Transaction latency is identical in both builds.

## Test plan
- **Reset/idle:** Hold `rst_n`=0 for 2 clks, then release and run 20 clks. Required: `SS_n`=1, `SCLK`=1, `MOSI`=0, `done`=0 throughout.
- **Loopback:** Tie MISO=MOSI, pulse `wrt` with `cmd`=16'hA5C3. Required:
  - exactly 16 SCLK rises;
  - `done` rises at E0+261;
  - `rd_data`=16'hA5C3.
- **WHO_AM_I read:** Run against the `SegwayModel` sensor with `cmd`=16'h8F00. Required: `rd_data[7:0]`=8'h6A.
- **Register write:** `cmd`=16'h0D02, then read back with `cmd`=16'h8D00. Required: `rd_data[7:0]`=8'h02, and `SegwayModel` register 0x0D=8'h02.
- **Ignored wrt:** Pulse `wrt` again with `cmd`=16'hFFFF at E0+100 during a 16'h1234 loopback. Required: `rd_data`=16'h1234, and `done` rises at E0+261 only.
- **Reset mid-transfer:** Assert `rst_n`=0 at E0+130. Required: on the next edge `SS_n`=1, `SCLK`=1, `rd_data`=0, and no `done`.
